id_rf_read_sched: RTL and testbench
===================================

# id_rf_read_sched

Register-file read scheduler between the ID stage decoders and a single-read-port register file. It accepts one operand-read request per instruction: up to two source registers, each with a read enable. It serializes the reads onto the one port, skips x0 and duplicate reads, forwards same-cycle writeback data, and returns both operands with a one-cycle response pulse. While reads are pending it drives a stall to the pipeline controller.

## Interface
Parameters:
- `ADDR_W`, default 5: register address width.
- `DATA_W`, default 32: register data width.

Ports (clock and reset first):
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `flush_i` input 1: synchronous abort of the current request.
- `req_valid_i` input 1: ID presents a read request.
- `req_ready_o` output 1: scheduler can accept a request.
- `reg1_re_i` input 1: operand 1 read enable.
- `reg1_raddr_i` input ADDR_W: operand 1 address.
- `reg2_re_i` input 1: operand 2 read enable.
- `reg2_raddr_i` input ADDR_W: operand 2 address.
- `rf_re_o` output 1: register-file port read enable.
- `rf_raddr_o` output ADDR_W: register-file port address.
- `rf_rdata_i` input DATA_W: register-file data, combinational and valid in the same cycle as `rf_raddr_o`.
- `wb_we_i` input 1: writeback write enable.
- `wb_waddr_i` input ADDR_W: writeback address.
- `wb_wdata_i` input DATA_W: writeback data.
- `rsp_valid_o` output 1: one-cycle pulse; operands valid.
- `reg1_rdata_o` output DATA_W: operand 1, registered.
- `reg2_rdata_o` output DATA_W: operand 2, registered.
- `stall_o` output 1: stall request to the pipeline controller.

## Operation
- States: IDLE, RD1, RD2, RSP. Reset state is IDLE.
- Accept: in IDLE, when `req_valid_i`=1, the enables and addresses are latched on the edge. `req_ready_o` = (state==IDLE).
- Need flags, computed from the latched values:
  - n1 = re1 && a1!=0.
  - n2 = re2 && a2!=0 && !(n1 && a2==a1).
  - dup = n1 && re2 && a2==a1.
- Transitions:
  - From IDLE on accept: to RD1 if n1, else to RD2 if n2, else to RSP.
  - RD1: to RD2 if n2, else to RSP.
  - RD2: to RSP.
  - RSP: to IDLE.
- RD1:
  - Drives `rf_re_o`=1 and `rf_raddr_o`=a1.
  - At the edge, op1 ← `rf_rdata_i`, and op2 ← the same value if dup.
- RD2:
  - Drives `rf_re_o`=1 and `rf_raddr_o`=a2.
  - At the edge, op2 ← `rf_rdata_i`.
- Outside RD1/RD2: `rf_re_o`=0 and `rf_raddr_o`=0.
- Operands are cleared to 0 on accept.
  - An operand with re=0 or address 0 stays 0.
  - x0 never uses the port.
- Forwarding: in RD1 and RD2, if `wb_we_i` and `wb_waddr_i`!=0, then on that edge:
  - Operand k takes `wb_wdata_i` when `wb_waddr_i`==ak and rek=1.
  - This applies whether or not operand k is read or captured that cycle, and it overrides `rf_rdata_i`.
  - The writeback is applied to both operands when both addresses match.
- No forwarding in IDLE or RSP. A write committed on the accept edge is seen by the register file in RD1.
- RSP: `rsp_valid_o`=1 for exactly one cycle. `reg1_rdata_o`/`reg2_rdata_o` hold until the next accept.
- `stall_o` = (IDLE && `req_valid_i`) || RD1 || RD2. It is 0 in RSP.
- `flush_i`:
  - In any state, the next state is IDLE and there is no `rsp_valid_o` pulse for the current request.
  - Operand registers are left unchanged.
  - `flush_i` in IDLE blocks an accept in that cycle.

## Timing
- Reset values: state IDLE, `req_ready_o`=1, `rsp_valid_o`=0, `rf_re_o`=0, `rf_raddr_o`=0, `stall_o`=0, `reg1_rdata_o`=0, `reg2_rdata_o`=0.
- Latency from the accept edge to the `rsp_valid_o` cycle:
  - Two reads: 3 cycles.
  - One read (including dup): 2 cycles.
  - No reads: 1 cycle.
- Throughput: one request per (latency + 1) cycles. `req_valid_i` during RD1, RD2 or RSP is ignored; ID holds the request until `req_ready_o`.
- Reset asserted mid-request: all outputs return to reset values immediately (asynchronous), with no response.

## Test plan
- Two reads: with rf[3]=0x11 and rf[7]=0x22, request re1=re2=1, a1=3, a2=7.
  - Required: `rf_raddr_o` is 3, then 7.
  - `rsp_valid_o` pulses 3 cycles after accept with op1=0x11, op2=0x22.
  - `stall_o` is high for 3 cycles.
- x0 and disabled operand: a1=0, re2=0, request accepted.
  - Required: no `rf_re_o` activity.
  - Response 1 cycle after accept with op1=op2=0.
- Duplicate address: a1=a2=5 with rf[5]=0xAB.
  - Required: a single port read.
  - Response at +2 with both operands 0xAB.
- Forwarding: two reads a1=4, a2=9 with rf[4]=0x1.
  - Stimulus: during RD2, `wb_we_i`=1, `wb_waddr_i`=4, `wb_wdata_i`=0x55.
  - Required: op1=0x55 in the response.
  - Stimulus: a write to x0 during RD1.
  - Required: no effect.
- Flush and reset:
  - `flush_i` in RD1: required IDLE on the next cycle, no `rsp_valid_o`, and `req_ready_o`=1.
  - `rst` low in RD2: required all outputs at reset values immediately.
- Back-to-back: `req_valid_i` held high for two requests.
  - Required: the second is accepted only in the cycle after RSP.
  - The first response's operands stay stable until the second accept.

Source files
------------

// File: rtl/id_rf_read_sched_if.sv
// ID-side bus of the register-file read scheduler: the operand-read
// request, the operand response and the stall to the pipeline controller.
interface id_rf_read_sched_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              reg1_re_i;
    logic [ADDR_W-1:0] reg1_raddr_i;
    logic              reg2_re_i;
    logic [ADDR_W-1:0] reg2_raddr_i;
    logic              rsp_valid_o;
    logic [DATA_W-1:0] reg1_rdata_o;
    logic [DATA_W-1:0] reg2_rdata_o;
    logic              stall_o;

    // ID decoder side: issues requests, consumes operands
    modport master (
        output req_valid_i, reg1_re_i, reg1_raddr_i, reg2_re_i, reg2_raddr_i,
        input  req_ready_o, rsp_valid_o, reg1_rdata_o, reg2_rdata_o, stall_o
    );

    // Scheduler side
    modport slave (
        input  req_valid_i, reg1_re_i, reg1_raddr_i, reg2_re_i, reg2_raddr_i,
        output req_ready_o, rsp_valid_o, reg1_rdata_o, reg2_rdata_o, stall_o
    );
endinterface

// File: rtl/id_rf_read_sched.sv
// Register-file read scheduler: serializes up to two operand reads onto a
// single read port, skips x0 and duplicate reads, forwards same-cycle
// writeback data and returns both operands with a one-cycle response pulse.
module id_rf_read_sched #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    id_rf_read_sched_if.slave    id_if,
    output logic                 rf_re_o,
    output logic [ADDR_W-1:0]    rf_raddr_o,
    input  logic [DATA_W-1:0]    rf_rdata_i,
    input  logic                 wb_we_i,
    input  logic [ADDR_W-1:0]    wb_waddr_i,
    input  logic [DATA_W-1:0]    wb_wdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD1  = 2'd1,
        ST_RD2  = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    // Operand 1 needs the port unless disabled or x0
    function automatic logic need1(input logic re1, input logic [ADDR_W-1:0] a1);
        return re1 && (a1 != ADDR_ZERO);
    endfunction

    // Operand 2 needs the port unless disabled, x0 or already read as operand 1
    function automatic logic need2(input logic re1, input logic [ADDR_W-1:0] a1,
                                   input logic re2, input logic [ADDR_W-1:0] a2);
        return re2 && (a2 != ADDR_ZERO) && !(need1(re1, a1) && (a2 == a1));
    endfunction

    // Operand 2 is a copy of operand 1's port read
    function automatic logic dup2(input logic re1, input logic [ADDR_W-1:0] a1,
                                  input logic re2, input logic [ADDR_W-1:0] a2);
        return need1(re1, a1) && re2 && (a2 == a1);
    endfunction

    state_t            state_q, state_d;
    logic              re1_q, re1_d, re2_q, re2_d;
    logic [ADDR_W-1:0] a1_q, a1_d, a2_q, a2_d;
    logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d;
    logic [DATA_W-1:0] cap1_s, cap2_s;
    logic              fwd1_s, fwd2_s, wb_fwd_s, accept_s;
    logic              in_n1_s, in_n2_s, q_n2_s, q_dup_s;

    assign accept_s = (state_q == ST_IDLE) && id_if.req_valid_i && !flush_i;
    assign in_n1_s  = need1(id_if.reg1_re_i, id_if.reg1_raddr_i);
    assign in_n2_s  = need2(id_if.reg1_re_i, id_if.reg1_raddr_i,
                            id_if.reg2_re_i, id_if.reg2_raddr_i);
    assign q_n2_s   = need2(re1_q, a1_q, re2_q, a2_q);
    assign q_dup_s  = dup2(re1_q, a1_q, re2_q, a2_q);
    assign wb_fwd_s = wb_we_i && (wb_waddr_i != ADDR_ZERO);

    // Next-state logic; flush always returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = in_n1_s ? ST_RD1 : (in_n2_s ? ST_RD2 : ST_RSP);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD1:  state_d = flush_i ? ST_IDLE : (q_n2_s ? ST_RD2 : ST_RSP);
            ST_RD2:  state_d = flush_i ? ST_IDLE : ST_RSP;
            ST_RSP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latch and operand capture with writeback forwarding over port data
    always_comb begin
        re1_d  = re1_q;
        re2_d  = re2_q;
        a1_d   = a1_q;
        a2_d   = a2_q;
        op1_d  = op1_q;
        op2_d  = op2_q;
        cap1_s = op1_q;
        cap2_s = op2_q;
        fwd1_s = 1'b0;
        fwd2_s = 1'b0;
        case (state_q)
            ST_RD1: begin
                cap1_s = rf_rdata_i;
                cap2_s = q_dup_s ? rf_rdata_i : op2_q;
                fwd1_s = wb_fwd_s && re1_q && (wb_waddr_i == a1_q);
                fwd2_s = wb_fwd_s && re2_q && (wb_waddr_i == a2_q);
            end
            ST_RD2: begin
                cap2_s = rf_rdata_i;
                fwd1_s = wb_fwd_s && re1_q && (wb_waddr_i == a1_q);
                fwd2_s = wb_fwd_s && re2_q && (wb_waddr_i == a2_q);
            end
            default: begin
                cap1_s = op1_q;
                cap2_s = op2_q;
            end
        endcase
        if (flush_i) begin
            op1_d = op1_q;
            op2_d = op2_q;
        end else if (accept_s) begin
            re1_d = id_if.reg1_re_i;
            re2_d = id_if.reg2_re_i;
            a1_d  = id_if.reg1_raddr_i;
            a2_d  = id_if.reg2_raddr_i;
            op1_d = DATA_ZERO;
            op2_d = DATA_ZERO;
        end else begin
            op1_d = fwd1_s ? wb_wdata_i : cap1_s;
            op2_d = fwd2_s ? wb_wdata_i : cap2_s;
        end
    end

    // Register-file port drive, decoded from the state
    always_comb begin
        rf_re_o    = 1'b0;
        rf_raddr_o = ADDR_ZERO;
        case (state_q)
            ST_RD1: begin
                rf_re_o    = 1'b1;
                rf_raddr_o = a1_q;
            end
            ST_RD2: begin
                rf_re_o    = 1'b1;
                rf_raddr_o = a2_q;
            end
            default: begin
                rf_re_o    = 1'b0;
                rf_raddr_o = ADDR_ZERO;
            end
        endcase
    end

    assign id_if.req_ready_o  = (state_q == ST_IDLE);
    assign id_if.rsp_valid_o  = (state_q == ST_RSP) && !flush_i;
    assign id_if.stall_o      = ((state_q == ST_IDLE) && id_if.req_valid_i) ||
                                (state_q == ST_RD1) || (state_q == ST_RD2);
    assign id_if.reg1_rdata_o = op1_q;
    assign id_if.reg2_rdata_o = op2_q;

    // State, request latch and operand registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            re1_q   <= 1'b0;
            re2_q   <= 1'b0;
            a1_q    <= ADDR_ZERO;
            a2_q    <= ADDR_ZERO;
            op1_q   <= DATA_ZERO;
            op2_q   <= DATA_ZERO;
        end else begin
            state_q <= state_d;
            re1_q   <= re1_d;
            re2_q   <= re2_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
        end
    end

endmodule

// File: tb/tb_id_rf_read_sched.sv
// Directed bench for id_rf_read_sched with a small register-file model.
module tb_id_rf_read_sched;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              rf_re;
    logic [ADDR_W-1:0] rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_waddr;
    logic [DATA_W-1:0] wb_wdata;
    logic [DATA_W-1:0] rf_mem [0:31];

    int checks   = 0;
    int failures = 0;

    id_rf_read_sched_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) id_if ();

    id_rf_read_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush),
        .id_if      (id_if.slave),
        .rf_re_o    (rf_re),
        .rf_raddr_o (rf_raddr),
        .rf_rdata_i (rf_rdata),
        .wb_we_i    (wb_we),
        .wb_waddr_i (wb_waddr),
        .wb_wdata_i (wb_wdata)
    );

    assign rf_rdata = rf_mem[rf_raddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Advance to the next falling edge, then settle combinational outputs
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic re1, input logic [ADDR_W-1:0] a1,
                           input logic re2, input logic [ADDR_W-1:0] a2);
        id_if.req_valid_i  = v;
        id_if.reg1_re_i    = re1;
        id_if.reg1_raddr_i = a1;
        id_if.reg2_re_i    = re2;
        id_if.reg2_raddr_i = a2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"}, 64'(id_if.req_ready_o), 64'd1);
        check_val({tag, "_rsp"},   64'(id_if.rsp_valid_o), 64'd0);
        check_val({tag, "_rf_re"}, 64'(rf_re), 64'd0);
        check_val({tag, "_raddr"}, 64'(rf_raddr), 64'd0);
        check_val({tag, "_stall"}, 64'(id_if.stall_o), 64'd0);
        check_val({tag, "_op1"},   64'(id_if.reg1_rdata_o), 64'd0);
        check_val({tag, "_op2"},   64'(id_if.reg2_rdata_o), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0000_1000 + 32'(i);
        rf_mem[0] = 32'h0;
        rf_mem[3] = 32'h11;
        rf_mem[7] = 32'h22;
        rf_mem[5] = 32'hAB;
        rf_mem[4] = 32'h1;
        rf_mem[9] = 32'h99;

        rst = 1'b0; flush = 1'b0;
        wb_we = 1'b0; wb_waddr = 5'd0; wb_wdata = 32'h0;
        set_req(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        cyc(); cyc();
        check_reset_outputs("reset");
        rst = 1'b1;
        cyc();

        // Two reads: x3 then x7
        set_req(1'b1, 1'b1, 5'd3, 1'b1, 5'd7);
        #1;
        check_val("t1_stall_idle", 64'(id_if.stall_o), 64'd1);
        cyc(); set_req(1'b0, 1'b0, 5'd0, 1'b0, 5'd0); #1;
        check_val("t1_rd1_re",    64'(rf_re), 64'd1);
        check_val("t1_rd1_addr",  64'(rf_raddr), 64'd3);
        check_val("t1_rd1_stall", 64'(id_if.stall_o), 64'd1);
        check_val("t1_rd1_rsp",   64'(id_if.rsp_valid_o), 64'd0);
        cyc();
        check_val("t1_rd2_addr",  64'(rf_raddr), 64'd7);
        check_val("t1_rd2_stall", 64'(id_if.stall_o), 64'd1);
        cyc();
        check_val("t1_rsp",       64'(id_if.rsp_valid_o), 64'd1);
        check_val("t1_op1",       64'(id_if.reg1_rdata_o), 64'h11);
        check_val("t1_op2",       64'(id_if.reg2_rdata_o), 64'h22);
        check_val("t1_rsp_stall", 64'(id_if.stall_o), 64'd0);
        check_val("t1_rsp_rfre",  64'(rf_re), 64'd0);
        cyc();
        check_val("t1_post_rsp",  64'(id_if.rsp_valid_o), 64'd0);
        check_val("t1_post_rdy",  64'(id_if.req_ready_o), 64'd1);

        // x0 and disabled operand: no port use, response next cycle
        set_req(1'b1, 1'b1, 5'd0, 1'b0, 5'd7);
        cyc(); set_req(1'b0, 1'b0, 5'd0, 1'b0, 5'd0); #1;
        check_val("t2_rf_re", 64'(rf_re), 64'd0);
        check_val("t2_rsp",   64'(id_if.rsp_valid_o), 64'd1);
        check_val("t2_op1",   64'(id_if.reg1_rdata_o), 64'd0);
        check_val("t2_op2",   64'(id_if.reg2_rdata_o), 64'd0);
        cyc();

        // Duplicate address: single read of x5 feeds both operands
        set_req(1'b1, 1'b1, 5'd5, 1'b1, 5'd5);
        cyc(); set_req(1'b0, 1'b0, 5'd0, 1'b0, 5'd0); #1;
        check_val("t3_rd_addr", 64'(rf_raddr), 64'd5);
        check_val("t3_rd_rsp",  64'(id_if.rsp_valid_o), 64'd0);
        cyc();
        check_val("t3_rf_re",   64'(rf_re), 64'd0);
        check_val("t3_rsp",     64'(id_if.rsp_valid_o), 64'd1);
        check_val("t3_op1",     64'(id_if.reg1_rdata_o), 64'hAB);
        check_val("t3_op2",     64'(id_if.reg2_rdata_o), 64'hAB);
        cyc();

        // Forwarding: x0 write in RD1 ignored, x4 write in RD2 overrides op1
        set_req(1'b1, 1'b1, 5'd4, 1'b1, 5'd9);
        cyc(); set_req(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        wb_we = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'hDEAD; #1;
        check_val("t4_rd1_addr", 64'(rf_raddr), 64'd4);
        cyc();
        wb_we = 1'b1; wb_waddr = 5'd4; wb_wdata = 32'h55; #1;
        check_val("t4_rd2_addr", 64'(rf_raddr), 64'd9);
        check_val("t4_rd2_op1",  64'(id_if.reg1_rdata_o), 64'h1);
        cyc();
        wb_we = 1'b0; wb_waddr = 5'd0; wb_wdata = 32'h0; #1;
        check_val("t4_rsp",      64'(id_if.rsp_valid_o), 64'd1);
        check_val("t4_op1_fwd",  64'(id_if.reg1_rdata_o), 64'h55);
        check_val("t4_op2",      64'(id_if.reg2_rdata_o), 64'h99);
        cyc();

        // x0 write while operand 1 addresses x0 must leave it zero
        set_req(1'b1, 1'b1, 5'd0, 1'b1, 5'd9);
        cyc(); set_req(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        wb_we = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'hDEAD; #1;
        check_val("t4b_rd2_addr", 64'(rf_raddr), 64'd9);
        cyc();
        wb_we = 1'b0; #1;
        check_val("t4b_rsp",      64'(id_if.rsp_valid_o), 64'd1);
        check_val("t4b_op1_x0",   64'(id_if.reg1_rdata_o), 64'd0);
        check_val("t4b_op2",      64'(id_if.reg2_rdata_o), 64'h99);
        cyc();

        // Flush in RD1: back to IDLE, no response, operands untouched
        set_req(1'b1, 1'b1, 5'd3, 1'b1, 5'd7);
        cyc(); set_req(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        flush = 1'b1; #1;
        check_val("t5_rd1_re", 64'(rf_re), 64'd1);
        cyc();
        flush = 1'b0; #1;
        check_val("t5_ready",  64'(id_if.req_ready_o), 64'd1);
        check_val("t5_rsp",    64'(id_if.rsp_valid_o), 64'd0);
        check_val("t5_rf_re",  64'(rf_re), 64'd0);
        check_val("t5_op1",    64'(id_if.reg1_rdata_o), 64'd0);
        cyc();
        check_val("t5_rsp2",   64'(id_if.rsp_valid_o), 64'd0);

        // Asynchronous reset in RD2
        set_req(1'b1, 1'b1, 5'd3, 1'b1, 5'd7);
        cyc(); set_req(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        cyc();
        check_val("t6_rd2_addr", 64'(rf_raddr), 64'd7);
        check_val("t6_rd2_op1",  64'(id_if.reg1_rdata_o), 64'h11);
        rst = 1'b0; #1;
        check_reset_outputs("t6_rst");
        cyc();
        rst = 1'b1; #1;
        check_val("t6_no_rsp", 64'(id_if.rsp_valid_o), 64'd0);
        cyc();

        // Back-to-back: second request waits until the cycle after RSP
        set_req(1'b1, 1'b1, 5'd3, 1'b1, 5'd7);
        cyc(); set_req(1'b1, 1'b1, 5'd5, 1'b0, 5'd0); #1;
        check_val("t7_rd1_ready", 64'(id_if.req_ready_o), 64'd0);
        cyc();
        check_val("t7_rd2_ready", 64'(id_if.req_ready_o), 64'd0);
        cyc();
        check_val("t7_rsp",       64'(id_if.rsp_valid_o), 64'd1);
        check_val("t7_rsp_ready", 64'(id_if.req_ready_o), 64'd0);
        cyc();
        check_val("t7_idle_ready", 64'(id_if.req_ready_o), 64'd1);
        check_val("t7_idle_rf_re", 64'(rf_re), 64'd0);
        check_val("t7_hold_op1",   64'(id_if.reg1_rdata_o), 64'h11);
        check_val("t7_hold_op2",   64'(id_if.reg2_rdata_o), 64'h22);
        check_val("t7_idle_stall", 64'(id_if.stall_o), 64'd1);
        cyc(); set_req(1'b0, 1'b0, 5'd0, 1'b0, 5'd0); #1;
        check_val("t7_2nd_addr",  64'(rf_raddr), 64'd5);
        check_val("t7_2nd_clr",   64'(id_if.reg1_rdata_o), 64'd0);
        cyc();
        check_val("t7_2nd_rsp",   64'(id_if.rsp_valid_o), 64'd1);
        check_val("t7_2nd_op1",   64'(id_if.reg1_rdata_o), 64'hAB);
        check_val("t7_2nd_op2",   64'(id_if.reg2_rdata_o), 64'd0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
